// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: state encoding and default width.
package counter_pkg;

    localparam logic ST_IDLE       = 1'b0;
    localparam logic ST_RUN        = 1'b1;
    localparam int   CNT_WIDTH_DEF = 4;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN
    } state_e;

endpackage

// File: rtl/sync_down_timer_if.sv
// Control/status bundle of the down-timer; the master drives commands, the timer reports count and status.
interface sync_down_timer_if #(
    parameter int WIDTH = counter_pkg::CNT_WIDTH_DEF
);
    logic             load;
    logic [WIDTH-1:0] din_d;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] dout_q;
    logic             busy;
    logic             done;

    modport master (
        output load, din_d, start, stop, auto_reload,
        input  dout_q, busy, done
    );

    modport slave (
        input  load, din_d, start, stop, auto_reload,
        output dout_q, busy, done
    );
endinterface

// File: rtl/tff_en.sv
// T flip-flop with toggle enable and asynchronous active-low clear.
module tff_en (
    input  logic clock,
    input  logic reset,
    input  logic din_t,
    output logic dout_q,
    output logic dout_nq
);
    logic q_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     q_q <= 1'b0;
        else if (din_t) q_q <= ~q_q;
    end

    assign dout_q  = q_q;
    assign dout_nq = ~q_q;
endmodule

// File: rtl/sync_down_timer.sv
// Loadable down-counter timer built from T flip-flops; one-shot or periodic with a registered done pulse.
module sync_down_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic            clock,
    input  logic            reset,
    sync_down_timer_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] cnt, cnt_n, tgt, tog, dec_t;
    logic             force_sel, cnt_en;
    logic             is_zero, is_one;

    assign is_zero = &cnt_n;
    assign is_one  = (cnt == WIDTH'(1));

    always_comb begin
        state_d   = state_q;
        reload_d  = reload_q;
        done_d    = 1'b0;
        force_sel = 1'b0;
        tgt       = '0;
        cnt_en    = 1'b0;
        if (bus.load) begin
            reload_d  = bus.din_d;
            force_sel = 1'b1;
            tgt       = bus.din_d;
            state_d   = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.stop && bus.start && !is_zero) state_d = S_RUN;
                end
                S_RUN: begin
                    if (bus.stop) begin
                        state_d = S_IDLE;
                    end else if (is_one) begin
                        done_d = 1'b1;
                        // A zero reload would re-enter RUN at 0, so fall back to one-shot.
                        if (bus.auto_reload && (reload_q != '0)) begin
                            force_sel = 1'b1;
                            tgt       = reload_q;
                        end else begin
                            cnt_en  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Bit i toggles on a decrement when every lower bit is 0 (borrow ripple);
    // loads force the toggle to q XOR target instead.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign dec_t[i] = cnt_en;
        end else begin : g_up
            assign dec_t[i] = cnt_en & (&cnt_n[i-1:0]);
        end
        assign tog[i] = force_sel ? (cnt[i] ^ tgt[i]) : dec_t[i];

        tff_en u_tff (
            .clock   (clock),
            .reset   (reset),
            .din_t   (tog[i]),
            .dout_q  (cnt[i]),
            .dout_nq (cnt_n[i])
        );
    end

    assign bus.dout_q = cnt;
    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = done_q;
endmodule

// File: tb/tb_sync_down_timer.sv
// Scoreboard bench for sync_down_timer: per-cycle stimulus rows push expected outputs, popped after each edge.
module tb_sync_down_timer;
    localparam int W = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    sync_down_timer_if #(.WIDTH(W)) bus ();

    sync_down_timer #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] dout;
        logic         busy;
        logic         done;
    } exp_t;

    typedef struct packed {
        logic         ld;
        logic [W-1:0] d;
        logic         st;
        logic         sp;
        logic         ar;
        exp_t         e;
    } row_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic row_t mk(bit ld, int d, bit st, bit sp, bit ar, int ed, bit eb, bit edn);
        row_t r;
        r.ld     = ld;
        r.d      = W'(d);
        r.st     = st;
        r.sp     = sp;
        r.ar     = ar;
        r.e.dout = W'(ed);
        r.e.busy = eb;
        r.e.done = edn;
        return r;
    endfunction

    task automatic apply(input row_t r);
        @(negedge clock);
        bus.load        = r.ld;
        bus.din_d       = r.d;
        bus.start       = r.st;
        bus.stop        = r.sp;
        bus.auto_reload = r.ar;
        sbq.push_back(r.e);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        row_t q[$];
        exp_t e;
        #2;
        n_checks++;
        if (bus.dout_q !== '0) begin n_fail++; $display("FAIL reset_dout got=%0d want=0", bus.dout_q); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", bus.done); end
        @(negedge clock);
        reset = 1'b1;
        q.push_back(mk(1, 9, 0, 0, 0, 9, 0, 0));
        q.push_back(mk(0, 0, 1, 0, 0, 9, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 8, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 7, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 6, 1, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sbq.pop_front();
            n_checks++;
            if ({bus.dout_q, bus.busy, bus.done} !== e) begin
                n_fail++;
                $display("FAIL reset_run[%0d] got dout=%0d busy=%b done=%b want dout=%0d busy=%b done=%b",
                         i, bus.dout_q, bus.busy, bus.done, e.dout, e.busy, e.done);
            end
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.dout_q, bus.busy, bus.done} !== {W'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async got dout=%0d busy=%b done=%b want dout=0 busy=0 done=0",
                     bus.dout_q, bus.busy, bus.done);
        end
        @(negedge clock);
        reset = 1'b1;
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0));
        e = sbq.pop_front();
        n_checks++;
        if ({bus.dout_q, bus.busy, bus.done} !== e) begin
            n_fail++;
            $display("FAIL reset_start got dout=%0d busy=%b done=%b want dout=%0d busy=%b done=%b",
                     bus.dout_q, bus.busy, bus.done, e.dout, e.busy, e.done);
        end
    endtask

    task automatic test_oneshot();
        row_t q[$];
        exp_t e;
        q.push_back(mk(1, 3, 0, 0, 0, 3, 0, 0));
        q.push_back(mk(0, 0, 1, 0, 0, 3, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sbq.pop_front();
            n_checks++;
            if ({bus.dout_q, bus.busy, bus.done} !== e) begin
                n_fail++;
                $display("FAIL oneshot[%0d] got dout=%0d busy=%b done=%b want dout=%0d busy=%b done=%b",
                         i, bus.dout_q, bus.busy, bus.done, e.dout, e.busy, e.done);
            end
        end
    endtask

    task automatic test_auto_reload();
        row_t q[$];
        exp_t e;
        q.push_back(mk(1, 4, 0, 0, 1, 4, 0, 0));
        q.push_back(mk(0, 0, 1, 0, 1, 4, 1, 0));
        for (int p = 0; p < 2; p++) begin
            q.push_back(mk(0, 0, 0, 0, 1, 3, 1, 0));
            q.push_back(mk(0, 0, 0, 0, 1, 2, 1, 0));
            q.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0));
            q.push_back(mk(0, 0, 0, 0, 1, 4, 1, 1));
        end
        q.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sbq.pop_front();
            n_checks++;
            if ({bus.dout_q, bus.busy, bus.done} !== e) begin
                n_fail++;
                $display("FAIL auto_reload[%0d] got dout=%0d busy=%b done=%b want dout=%0d busy=%b done=%b",
                         i, bus.dout_q, bus.busy, bus.done, e.dout, e.busy, e.done);
            end
        end
    endtask

    task automatic test_pause_resume();
        row_t q[$];
        exp_t e;
        q.push_back(mk(1, 10, 0, 0, 0, 10, 0, 0));
        q.push_back(mk(0, 0, 1, 0, 0, 10, 1, 0));
        for (int v = 9; v >= 7; v--) q.push_back(mk(0, 0, 0, 0, 0, v, 1, 0));
        q.push_back(mk(0, 0, 0, 1, 0, 7, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 7, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 7, 0, 0));
        q.push_back(mk(0, 0, 1, 0, 0, 7, 1, 0));
        for (int v = 6; v >= 1; v--) q.push_back(mk(0, 0, 0, 0, 0, v, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        foreach (q[i]) begin
            apply(q[i]);
            e = sbq.pop_front();
            n_checks++;
            if ({bus.dout_q, bus.busy, bus.done} !== e) begin
                n_fail++;
                $display("FAIL pause_resume[%0d] got dout=%0d busy=%b done=%b want dout=%0d busy=%b done=%b",
                         i, bus.dout_q, bus.busy, bus.done, e.dout, e.busy, e.done);
            end
        end
    endtask

    task automatic test_priority();
        row_t q[$];
        exp_t e;
        q.push_back(mk(1, 5, 1, 0, 0, 5, 0, 0));  // load beats start
        q.push_back(mk(0, 0, 1, 1, 0, 5, 0, 0));  // stop beats start in IDLE
        q.push_back(mk(0, 0, 1, 0, 0, 5, 1, 0));
        q.push_back(mk(0, 0, 1, 1, 0, 5, 0, 0));  // stop+start in RUN -> IDLE
        q.push_back(mk(1, 6, 0, 0, 0, 6, 0, 0));
        q.push_back(mk(0, 0, 1, 0, 0, 6, 1, 0));
        q.push_back(mk(1, 3, 1, 0, 0, 3, 0, 0));  // load in RUN -> IDLE
        q.push_back(mk(1, 2, 0, 0, 0, 2, 0, 0));
        q.push_back(mk(0, 0, 1, 0, 0, 2, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
        q.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0));  // stop on terminal edge
        q.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        foreach (q[i]) begin
            apply(q[i]);
            e = sbq.pop_front();
            n_checks++;
            if ({bus.dout_q, bus.busy, bus.done} !== e) begin
                n_fail++;
                $display("FAIL priority[%0d] got dout=%0d busy=%b done=%b want dout=%0d busy=%b done=%b",
                         i, bus.dout_q, bus.busy, bus.done, e.dout, e.busy, e.done);
            end
        end
    endtask

    task automatic test_edges();
        row_t q[$];
        exp_t e;
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 15, 0, 0, 0, 15, 0, 0));
        q.push_back(mk(0, 0, 1, 0, 0, 15, 1, 0));
        for (int v = 14; v >= 1; v--) q.push_back(mk(0, 0, 0, 0, 0, v, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        q.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0));
        q.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0));
        for (int k = 0; k < 4; k++) q.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sbq.pop_front();
            n_checks++;
            if ({bus.dout_q, bus.busy, bus.done} !== e) begin
                n_fail++;
                $display("FAIL edges[%0d] got dout=%0d busy=%b done=%b want dout=%0d busy=%b done=%b",
                         i, bus.dout_q, bus.busy, bus.done, e.dout, e.busy, e.done);
            end
        end
    endtask

    initial begin
        bus.load        = 1'b0;
        bus.din_d       = '0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.auto_reload = 1'b0;
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_pause_resume();
        test_priority();
        test_edges();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
